// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit-counter width; kept at least 1 so the counter never collapses to zero bits.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell; the serial adder runs every bit through this single slice.
module serial_adder_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, LSB first,
// WIDTH cycles per add with a one-cycle done pulse and held registered result.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Only the upper WIDTH-1 partial-sum bits need storing; the newest bit comes from the slice.
  logic [WIDTH-2:0] r_s_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_c_ff;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_s_next;

  serial_adder_full_adder u_fa (
    .i_a     (r_a_sh[0]),
    .i_b     (r_b_sh[0]),
    .i_c     (r_c_ff),
    .o_sum   (w_fa_sum),
    .o_carry (w_fa_carry)
  );

  assign w_last   = (r_cnt == CNT_LAST);
  assign w_s_next = {w_fa_sum, r_s_sh};

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_SHIFT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_s_sh <= '0;
      r_c_ff <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_load) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_c_ff <= cin;
      r_cnt  <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_s_sh <= w_s_next[WIDTH-1:1];
      r_c_ff <= w_fa_carry;
      r_cnt  <= r_cnt + CNT_W'(1);
      // Result registers move only on the final bit so they hold through the next add.
      if (w_last) begin
        r_sum  <= w_s_next;
        r_cout <= w_fa_carry;
      end
    end
  end

  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
